// File: rtl/pipe_exe_stage.sv
// Execute stage: ID/EXE register, operand forwarding, ALU, iterative multiplier, EXE/MEM register.
// One cycle per op, MUL_CYCLES for mul; ex_stall freezes IF/ID and ID/EXE while EXE/MEM drains bubbles.
module pipe_exe_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_pc4,
  input  logic [31:0] d_a,
  input  logic [31:0] d_b,
  input  logic [31:0] d_imm,
  input  logic [4:0]  d_rn,
  input  logic [4:0]  d_aluc,
  input  logic        d_wreg,
  input  logic        d_m2reg,
  input  logic        d_wmem,
  input  logic        d_aluimm,
  input  logic        d_shift,
  input  logic        d_jal,
  input  logic [1:0]  d_adepen,
  input  logic [1:0]  d_bdepen,
  input  logic        d_btaken,
  input  logic        ld_stall,
  input  logic [31:0] wb_data,
  output logic [4:0]  EXE_rd,
  output logic        EXE_wreg,
  output logic        EXE_SLD,
  output logic [4:0]  MEM_rd,
  output logic        MEM_wreg,
  output logic        eBTAKEN,
  output logic        ex_stall,
  output logic        m_wreg,
  output logic        m_m2reg,
  output logic        m_wmem,
  output logic [4:0]  m_rn,
  output logic [31:0] m_alu,
  output logic [31:0] m_b
);

  localparam int CW = $clog2(MUL_CYCLES);

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_XOR = 5'b00100;
  localparam logic [4:0] ALU_LUI = 5'b00101;
  localparam logic [4:0] ALU_SLL = 5'b00110;
  localparam logic [4:0] ALU_SRL = 5'b00111;
  localparam logic [4:0] ALU_SRA = 5'b01000;
  localparam logic [4:0] ALU_SLT = 5'b01001;
  localparam logic [4:0] ALU_MUL = 5'b01010;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rn;
    logic [4:0]  aluc;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic        aluimm;
    logic        shift;
    logic        jal;
    logic        btaken;
    logic [1:0]  adepen;
    logic [1:0]  bdepen;
  } idex_t;

  typedef enum logic {
    MUL_IDLE,
    MUL_BUSY
  } mul_state_t;

  idex_t       e;
  idex_t       idex_nxt;
  mul_state_t  mul_state;
  mul_state_t  mul_state_nxt;
  logic [CW-1:0] mul_cnt;
  logic [31:0] mul_acc;
  logic [31:0] mul_a;
  logic [31:0] mul_b;

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic [31:0] result;
  logic [31:0] step_acc;
  logic [31:0] step_a;
  logic [31:0] step_b;
  logic [31:0] mul_sum;
  logic        is_mul;
  logic        mul_last;

  // ID/EXE input; a load-use bubble keeps the data but kills every side effect.
  always_comb begin
    idex_nxt        = '0;
    idex_nxt.pc4    = d_pc4;
    idex_nxt.a      = d_a;
    idex_nxt.b      = d_b;
    idex_nxt.imm    = d_imm;
    idex_nxt.rn     = d_rn;
    idex_nxt.aluimm = d_aluimm;
    idex_nxt.shift  = d_shift;
    idex_nxt.jal    = d_jal;
    idex_nxt.adepen = d_adepen;
    idex_nxt.bdepen = d_bdepen;
    if (!ld_stall) begin
      idex_nxt.aluc   = d_aluc;
      idex_nxt.wreg   = d_wreg;
      idex_nxt.m2reg  = d_m2reg;
      idex_nxt.wmem   = d_wmem;
      idex_nxt.btaken = d_btaken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e <= '0;
    end else if (!ex_stall) begin
      e <= idex_nxt;
    end
  end

  always_comb begin
    case (e.adepen)
      2'b01:   fwd_a = m_alu;
      2'b10:   fwd_a = wb_data;
      default: fwd_a = e.a;
    endcase
    case (e.bdepen)
      2'b01:   fwd_b = m_alu;
      2'b10:   fwd_b = wb_data;
      default: fwd_b = e.b;
    endcase
  end

  assign alu_a = e.shift  ? {27'b0, e.imm[4:0]} : fwd_a;
  assign alu_b = e.aluimm ? e.imm : fwd_b;

  // The capture cycle already retires multiplier bit 0 from the live operands,
  // so the last of MUL_CYCLES steps completes combinationally in the final cycle.
  assign is_mul   = (e.aluc == ALU_MUL) && !e.jal;
  assign mul_last = (mul_state == MUL_BUSY) && (mul_cnt == CW'(MUL_CYCLES - 1));
  assign ex_stall = is_mul && !mul_last;

  always_comb begin
    step_acc = mul_acc;
    step_a   = mul_a;
    step_b   = mul_b;
    if (mul_state == MUL_IDLE) begin
      step_acc = '0;
      step_a   = alu_a;
      step_b   = alu_b;
    end
    mul_sum = step_acc + (step_b[0] ? step_a : 32'd0);
  end

  always_comb begin
    mul_state_nxt = mul_state;
    case (mul_state)
      MUL_IDLE: if (is_mul)   mul_state_nxt = MUL_BUSY;
      MUL_BUSY: if (mul_last) mul_state_nxt = MUL_IDLE;
      default:                mul_state_nxt = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_state <= MUL_IDLE;
      mul_cnt   <= '0;
      mul_acc   <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      mul_state <= mul_state_nxt;
      if (mul_state == MUL_BUSY || is_mul) begin
        mul_acc <= mul_sum;
        mul_a   <= step_a << 1;
        mul_b   <= step_b >> 1;
        mul_cnt <= mul_last ? '0 : mul_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    case (e.aluc)
      ALU_ADD: alu_out = alu_a + alu_b;
      ALU_SUB: alu_out = alu_a - alu_b;
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      ALU_XOR: alu_out = alu_a ^ alu_b;
      ALU_LUI: alu_out = {alu_b[15:0], 16'h0000};
      ALU_SLL: alu_out = alu_b << alu_a[4:0];
      ALU_SRL: alu_out = alu_b >> alu_a[4:0];
      ALU_SRA: alu_out = $signed(alu_b) >>> alu_a[4:0];
      ALU_SLT: alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_MUL: alu_out = mul_sum;
      default: alu_out = '0;
    endcase
  end

  assign result = e.jal ? e.pc4 + 32'd4 : alu_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_wreg  <= 1'b0;
      m_m2reg <= 1'b0;
      m_wmem  <= 1'b0;
      m_rn    <= '0;
      m_alu   <= '0;
      m_b     <= '0;
    end else begin
      m_wreg  <= e.wreg  & ~ex_stall;
      m_m2reg <= e.m2reg & ~ex_stall;
      m_wmem  <= e.wmem  & ~ex_stall;
      m_rn    <= e.rn;
      m_alu   <= result;
      m_b     <= fwd_b;
    end
  end

  assign EXE_rd   = e.rn;
  assign EXE_wreg = e.wreg;
  assign EXE_SLD  = e.wreg & e.m2reg;
  assign MEM_rd   = m_rn;
  assign MEM_wreg = m_wreg;
  assign eBTAKEN  = e.btaken;

endmodule

// File: tb/tb_pipe_exe_stage.sv
// Directed bench for pipe_exe_stage: ALU ops, forwarding, bubbles, multiplier stall and reset abort.
module tb_pipe_exe_stage;

  localparam logic [4:0] ADD = 5'b00000;
  localparam logic [4:0] SUB = 5'b00001;
  localparam logic [4:0] AND = 5'b00010;
  localparam logic [4:0] OR  = 5'b00011;
  localparam logic [4:0] XOR = 5'b00100;
  localparam logic [4:0] LUI = 5'b00101;
  localparam logic [4:0] SLL = 5'b00110;
  localparam logic [4:0] SRL = 5'b00111;
  localparam logic [4:0] SRA = 5'b01000;
  localparam logic [4:0] SLT = 5'b01001;
  localparam logic [4:0] MUL = 5'b01010;

  logic        clk;
  logic        rst;
  logic [31:0] d_pc4, d_a, d_b, d_imm;
  logic [4:0]  d_rn, d_aluc;
  logic        d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_jal;
  logic [1:0]  d_adepen, d_bdepen;
  logic        d_btaken, ld_stall;
  logic [31:0] wb_data;
  logic [4:0]  EXE_rd, MEM_rd, m_rn;
  logic        EXE_wreg, EXE_SLD, MEM_wreg, eBTAKEN, ex_stall;
  logic        m_wreg, m_m2reg, m_wmem;
  logic [31:0] m_alu, m_b;

  int checks = 0;
  int errors = 0;
  int stall_cnt;
  int bad;

  pipe_exe_stage #(.MUL_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .d_pc4(d_pc4), .d_a(d_a), .d_b(d_b), .d_imm(d_imm),
    .d_rn(d_rn), .d_aluc(d_aluc),
    .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem),
    .d_aluimm(d_aluimm), .d_shift(d_shift), .d_jal(d_jal),
    .d_adepen(d_adepen), .d_bdepen(d_bdepen),
    .d_btaken(d_btaken), .ld_stall(ld_stall), .wb_data(wb_data),
    .EXE_rd(EXE_rd), .EXE_wreg(EXE_wreg), .EXE_SLD(EXE_SLD),
    .MEM_rd(MEM_rd), .MEM_wreg(MEM_wreg), .eBTAKEN(eBTAKEN),
    .ex_stall(ex_stall),
    .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_wmem(m_wmem),
    .m_rn(m_rn), .m_alu(m_alu), .m_b(m_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nop();
    d_pc4 = 0; d_a = 0; d_b = 0; d_imm = 0; d_rn = 0; d_aluc = ADD;
    d_wreg = 0; d_m2reg = 0; d_wmem = 0; d_aluimm = 0; d_shift = 0; d_jal = 0;
    d_adepen = 0; d_bdepen = 0; d_btaken = 0;
  endtask

  task automatic issue(input logic [4:0] aluc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] rn,
                       input logic wreg, input logic m2reg, input logic wmem,
                       input logic aluimm, input logic shift, input logic jal,
                       input logic [1:0] adep, input logic [1:0] bdep);
    nop();
    d_aluc = aluc; d_a = a; d_b = b; d_imm = imm; d_rn = rn;
    d_wreg = wreg; d_m2reg = m2reg; d_wmem = wmem;
    d_aluimm = aluimm; d_shift = shift; d_jal = jal;
    d_adepen = adep; d_bdepen = bdep;
  endtask

  task automatic alu_case(input string tag, input logic [4:0] aluc, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm,
                          input logic aluimm, input logic shift, input logic [31:0] exp);
    issue(aluc, a, b, imm, 5'd1, 1'b1, 1'b0, 1'b0, aluimm, shift, 1'b0, 2'b00, 2'b00);
    tick();
    nop();
    tick();
    chk(tag, m_alu, exp);
  endtask

  initial begin
    rst = 1'b1; ld_stall = 1'b0; wb_data = 0;
    nop();
    tick();
    tick();
    chk("rst_m_alu", m_alu, 32'h0);
    chk("rst_m_wreg", {31'b0, m_wreg}, 32'h0);
    chk("rst_ex_stall", {31'b0, ex_stall}, 32'h0);
    chk("rst_EXE_wreg", {31'b0, EXE_wreg}, 32'h0);
    chk("rst_eBTAKEN", {31'b0, eBTAKEN}, 32'h0);
    chk("rst_MEM_rd", {27'b0, MEM_rd}, 32'h0);
    rst = 1'b0;

    // add 5+7
    issue(ADD, 32'd5, 32'd7, 0, 5'd3, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    d_btaken = 1'b1;
    tick();
    chk("add_EXE_rd", {27'b0, EXE_rd}, 32'd3);
    chk("add_EXE_wreg", {31'b0, EXE_wreg}, 32'd1);
    chk("btaken_reg", {31'b0, eBTAKEN}, 32'd1);
    nop();
    tick();
    chk("add_m_alu", m_alu, 32'd12);
    chk("add_m_wreg", {31'b0, m_wreg}, 32'd1);
    chk("add_m_rn", {27'b0, m_rn}, 32'd3);
    chk("add_MEM_rd", {27'b0, MEM_rd}, 32'd3);
    chk("btaken_clear", {31'b0, eBTAKEN}, 32'd0);

    // dependent pair through MEM forwarding
    issue(ADD, 32'd1, 32'd2, 0, 5'd3, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    tick();
    issue(SUB, 32'h55, 32'd1, 0, 5'd4, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00);
    tick();
    chk("dep_first", m_alu, 32'd3);
    nop();
    tick();
    chk("fwd_mem", m_alu, 32'd2);
    chk("fwd_mem_rn", {27'b0, m_rn}, 32'd4);

    // dependent pair with a gap, through WB forwarding
    issue(ADD, 32'd1, 32'd2, 0, 5'd3, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    tick();
    nop();
    tick();
    issue(SUB, 32'h55, 32'd1, 0, 5'd4, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00);
    wb_data = 32'd3;
    tick();
    nop();
    tick();
    chk("fwd_wb", m_alu, 32'd2);
    wb_data = 0;

    // select 11 behaves as 00 (MEM holds a nop result of 0 here)
    issue(ADD, 32'd10, 32'd1, 0, 5'd2, 1, 0, 0, 0, 0, 0, 2'b11, 2'b00);
    tick();
    nop();
    tick();
    chk("fwd_sel11", m_alu, 32'd11);

    // load-use bubble
    issue(ADD, 32'h100, 0, 32'd8, 5'd5, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00);
    ld_stall = 1'b1;
    tick();
    chk("bubble_EXE_wreg", {31'b0, EXE_wreg}, 32'd0);
    chk("bubble_EXE_SLD", {31'b0, EXE_SLD}, 32'd0);
    ld_stall = 1'b0;
    tick();
    chk("lw_EXE_SLD", {31'b0, EXE_SLD}, 32'd1);
    chk("lw_EXE_rd", {27'b0, EXE_rd}, 32'd5);
    chk("bubble_m_wreg", {31'b0, m_wreg}, 32'd0);
    chk("bubble_m_wmem", {31'b0, m_wmem}, 32'd0);
    nop();
    tick();
    chk("lw_m_alu", m_alu, 32'h108);
    chk("lw_m_m2reg", {31'b0, m_m2reg}, 32'd1);
    chk("lw_MEM_wreg", {31'b0, MEM_wreg}, 32'd1);

    // store
    issue(ADD, 32'h200, 32'hDEAD_BEEF, 32'd4, 5'd0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00);
    tick();
    nop();
    tick();
    chk("sw_m_alu", m_alu, 32'h204);
    chk("sw_m_b", m_b, 32'hDEAD_BEEF);
    chk("sw_m_wmem", {31'b0, m_wmem}, 32'd1);
    chk("sw_m_wreg", {31'b0, m_wreg}, 32'd0);

    // ALU op table
    alu_case("sub_wrap", SUB, 32'd0, 32'd1, 0, 0, 0, 32'hFFFF_FFFF);
    alu_case("and", AND, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 0, 0, 32'h00F0_1200);
    alu_case("or",  OR,  32'hF0F0_1234, 32'h0FF0_FF00, 0, 0, 0, 32'hFFF0_FF34);
    alu_case("xor", XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 0, 0, 32'hFF00_ED34);
    alu_case("lui", LUI, 32'd0, 32'd0, 32'h0000_1234, 1, 0, 32'h1234_0000);
    alu_case("sll", SLL, 32'd0, 32'h0000_00F1, 32'd4, 0, 1, 32'h0000_0F10);
    alu_case("srl", SRL, 32'd0, 32'h8000_0000, 32'd4, 0, 1, 32'h0800_0000);
    alu_case("sra", SRA, 32'd0, 32'h8000_0000, 32'd4, 0, 1, 32'hF800_0000);
    alu_case("slt_true", SLT, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 32'd1);
    alu_case("slt_false", SLT, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 32'd0);
    alu_case("undef_op", 5'b11111, 32'd5, 32'd7, 0, 0, 0, 32'd0);

    // jal ignores a mul opcode and links pc4+4
    issue(MUL, 0, 0, 0, 5'd31, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00);
    d_pc4 = 32'h100;
    tick();
    chk("jal_no_stall", {31'b0, ex_stall}, 32'd0);
    nop();
    tick();
    chk("jal_link", m_alu, 32'h104);

    // mul 0xFFFFFFFF * 3 with a dependent-free add waiting in ID
    issue(MUL, 32'hFFFF_FFFF, 32'd3, 0, 5'd6, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    tick();
    issue(ADD, 32'd10, 32'd20, 0, 5'd7, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    stall_cnt = 0;
    bad = 0;
    for (int k = 0; k < 40 && ex_stall; k++) begin
      stall_cnt++;
      tick();
      if (m_wreg !== 1'b0 || m_wmem !== 1'b0) bad++;
    end
    chk("mul_stall_cycles", stall_cnt, 32'd31);
    chk("mul_mem_bubbles", bad, 32'd0);
    chk("mul_held_EXE_rd", {27'b0, EXE_rd}, 32'd6);
    tick();
    chk("mul_product", m_alu, 32'hFFFF_FFFD);
    chk("mul_m_rn", {27'b0, m_rn}, 32'd6);
    chk("mul_m_wreg", {31'b0, m_wreg}, 32'd1);
    chk("after_mul_EXE_rd", {27'b0, EXE_rd}, 32'd7);
    nop();
    tick();
    chk("after_mul_add", m_alu, 32'd30);

    // reset in the middle of a multiply
    issue(MUL, 32'd5, 32'd5, 0, 5'd8, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    tick();
    nop();
    repeat (10) tick();
    chk("mid_mul_stall", {31'b0, ex_stall}, 32'd1);
    rst = 1'b1;
    tick();
    chk("abort_ex_stall", {31'b0, ex_stall}, 32'd0);
    chk("abort_EXE_rd", {27'b0, EXE_rd}, 32'd0);
    chk("abort_m_rn", {27'b0, m_rn}, 32'd0);
    chk("abort_m_alu", m_alu, 32'd0);
    chk("abort_EXE_wreg", {31'b0, EXE_wreg}, 32'd0);
    rst = 1'b0;

    issue(MUL, 32'd6, 32'd7, 0, 5'd9, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    tick();
    nop();
    stall_cnt = 0;
    for (int k = 0; k < 40 && ex_stall; k++) begin
      stall_cnt++;
      tick();
    end
    chk("mul2_stall_cycles", stall_cnt, 32'd31);
    tick();
    chk("mul2_product", m_alu, 32'd42);
    chk("mul2_m_rn", {27'b0, m_rn}, 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_exe_stage.md
Name: pipe_exe_stage

Overview:
- Execute stage of the five-stage pipelined CPU, sitting directly after the decode stage.
- Owns the ID/EXE pipeline register, operand forwarding muxes, ALU, a 32-cycle iterative multiplier and the EXE/MEM pipeline register.
- Consumes the decode stage's control, operands and forwarding selects.
- Returns EXE_rd, EXE_wreg, EXE_SLD, MEM_rd, MEM_wreg and eBTAKEN to decode for hazard detection, plus a stall when the multiplier is busy.

Parameters:
- MUL_CYCLES, 32, EXE cycles a mul occupies; counter width is clog2(MUL_CYCLES).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- d_pc4  in  32  PC+4 of the instruction in ID
- d_a, d_b, d_imm  in  32 each  regfile operands and extended immediate from ID
- d_rn  in  5  destination register from ID
- d_aluc  in  5  ALU opcode
- d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_jal  in  1 each  ID control
- d_adepen, d_bdepen  in  2 each  forwarding selects computed in ID
- d_btaken  in  1  branch taken, resolved in ID
- ld_stall  in  1  load-use stall request from ID
- wb_data  in  32  result being written back in WB
- EXE_rd  out  5  destination register of the instruction in EXE
- EXE_wreg, EXE_SLD  out  1 each  EXE writes a register / EXE is a load
- MEM_rd  out  5  destination register of the instruction in MEM
- MEM_wreg  out  1  MEM writes a register
- eBTAKEN  out  1  registered d_btaken
- ex_stall  out  1  multiplier busy; freeze IF/ID and ID/EXE
- m_wreg, m_m2reg, m_wmem  out  1 each  EXE/MEM control
- m_rn  out  5  EXE/MEM destination register
- m_alu, m_b  out  32 each  EXE/MEM result and store data

Behaviour:
- Reset: every ID/EXE and EXE/MEM register, every output, the mul FSM and the counter go to 0 on the rising clk edge with rst=1; a multiply in progress is abandoned.
- ID/EXE update priority: rst > ex_stall (hold all) > ld_stall (bubble: wreg, m2reg, wmem, btaken, aluc cleared; data don't-care) > load all d_* fields.
- eBTAKEN equals the ID/EXE btaken bit.
- EXE_rd / EXE_wreg are the ID/EXE rn and wreg fields. EXE_SLD = wreg & m2reg.
- MEM_rd / MEM_wreg are m_rn / m_wreg.
- Forwarding (per operand, select registered in ID/EXE):
  - 00: registered regfile value
  - 01: m_alu (producer now in MEM)
  - 10: wb_data (producer now in WB)
  - 11: treated as 00
- Operand A = shift ? {27'b0, imm[4:0]} : fwdA.
- Operand B = aluimm ? imm : fwdB.
- Store data m_b always takes fwdB.
- ALU codes:
  - 00000 add; 00001 sub; 00010 and; 00011 or; 00100 xor
  - 00101 lui = B<<16
  - 00110 sll = B<<A[4:0]; 00111 srl; 01000 sra
  - 01001 slt, signed, gives 1 or 0
  - 01010 mul, low 32 bits of the product
  - all other codes give 0
  - Arithmetic is 32-bit and wraps; no overflow trap.
- jal: result = pc4 + 4 (link address); aluc is ignored.
- Multiplier FSM, states IDLE and BUSY:
  - IDLE→BUSY when ID/EXE holds a valid mul (aluc=01010, not a bubble). On that edge it captures fwdA and B and clears the accumulator and counter.
  - BUSY performs one shift-add step per cycle.
  - ex_stall = 1 from the first EXE cycle of the mul through count=MUL_CYCLES-2.
  - At count=MUL_CYCLES-1 the result is valid combinationally and ex_stall = 0. The EXE/MEM register loads the product and the FSM returns to IDLE.
  - Total EXE occupancy is MUL_CYCLES cycles.
- EXE/MEM register:
  - While ex_stall=1 it loads a bubble (wreg, m2reg, wmem = 0) so MEM/WB drain.
  - Otherwise it loads wreg, m2reg, wmem, rn, result and store data.
- Simultaneous ex_stall and ld_stall: ex_stall wins; ld_stall is re-evaluated by ID after release.
- A back-to-back dependent mul forwards through m_alu as for any ALU op.

Test Plan:
- add, d_a=5, d_b=7, selects 00 -> m_alu=12 one cycle after ID/EXE load; m_wreg=1; m_rn=d_rn.
- Dependent pair: add r3=r1+r2 (r1=1, r2=2), then sub r4=r3-r1 with d_adepen=01 -> second m_alu=2; repeat with a gap and select 10, wb_data=3 -> 2.
- ld_stall=1 for one cycle with lw in ID -> ID/EXE bubble: EXE_wreg=0, EXE_SLD=0, next m_wmem=0; the following cycle loads normally.
- mul 0xFFFF_FFFF * 3 -> ex_stall high for exactly 31 cycles, then m_alu=0xFFFF_FFFD; 31 bubbles leave MEM meanwhile.
- rst asserted at count=10 of a mul -> next cycle ex_stall=0 and all outputs 0; a later mul 6*7 gives 42.
- jal with d_pc4=0x100 -> m_alu=0x104. sra 0x8000_0000 by 4 -> 0xF800_0000. slt -1<1 -> 1.
